// File: rtl/matmul_pkg.sv
// ============================================================================
// matmul_pkg : shared sizing helpers and types for the matrix datapath blocks
// Revision   : 1.0
// ============================================================================
`default_nettype none

package matmul_pkg;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  // Row counter width; a single-row matrix still gets one counter bit.
  function automatic int cnt_width(input int dim1);
    return (dim1 > 1) ? $clog2(dim1) : 1;
  endfunction

  function automatic int flat_width(input int data_width, input int dim0, input int dim1);
    return data_width * dim0 * dim1;
  endfunction

  localparam int DEFAULT_FLAT_WIDTH = flat_width(32, 4, 4);

endpackage : matmul_pkg

`default_nettype wire

// File: rtl/matrix_flatten.sv
// ============================================================================
// matrix_flatten : packs a DIM1 x DIM0 element array into a row-major vector
// Revision       : 1.0
// ============================================================================
`default_nettype none

module matrix_flatten
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM0       = 4,
  parameter int DIM1       = 4
) (
  input  logic [DATA_WIDTH-1:0]                 i_matrix [DIM1][DIM0],
  output logic [flat_width(DATA_WIDTH, DIM0, DIM1)-1:0] o_flat
);

  generate
    for (genvar r = 0; r < DIM1; r++) begin : g_row
      for (genvar c = 0; c < DIM0; c++) begin : g_col
        assign o_flat[(r*DIM0+c)*DATA_WIDTH +: DATA_WIDTH] = i_matrix[r][c];
      end
    end
  endgenerate

endmodule : matrix_flatten

`default_nettype wire

// File: rtl/matrix_row_gather.sv
// ============================================================================
// matrix_row_gather : assembles streamed rows into full matrices, ping-pong
//                     buffered, and presents each as one flattened vector
// Revision          : 1.0
// ============================================================================
`default_nettype none

module matrix_row_gather
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM0       = 4,
  parameter int DIM1       = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [DATA_WIDTH-1:0]                         data_in [DIM0-1:0],
  input  logic                                          data_in_valid,
  output logic                                          data_in_ready,
  output logic [flat_width(DATA_WIDTH, DIM0, DIM1)-1:0] data_out,
  output logic                                          data_out_valid,
  input  logic                                          data_out_ready
);

  localparam int CW = cnt_width(DIM1);

  logic [DATA_WIDTH-1:0] r_bank [2][DIM1][DIM0];
  bank_e                 r_wr_bank;
  bank_e                 r_rd_bank;
  logic [CW-1:0]         r_row_cnt;
  logic [1:0]            r_full;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_last_row;
  logic [1:0]            w_full_next;
  logic [DATA_WIDTH-1:0] w_rd_matrix [DIM1][DIM0];

  // Ready depends only on registered state, never on data_out_ready.
  assign data_in_ready  = !r_full[r_wr_bank];
  assign data_out_valid = r_full[r_rd_bank];

  assign w_in_fire  = data_in_valid && data_in_ready;
  assign w_out_fire = data_out_valid && data_out_ready;
  assign w_last_row = (r_row_cnt == CW'(DIM1 - 1));

  // Write and drain always hit different banks, so both updates can apply.
  always_comb begin
    w_full_next = r_full;
    if (w_out_fire) begin
      w_full_next[r_rd_bank] = 1'b0;
    end
    if (w_in_fire && w_last_row) begin
      w_full_next[r_wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= BANK_A;
      r_rd_bank <= BANK_A;
      r_row_cnt <= '0;
      r_full    <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < DIM1; r++) begin
          for (int c = 0; c < DIM0; c++) begin
            r_bank[b][r][c] <= '0;
          end
        end
      end
    end else begin
      if (w_in_fire) begin
        for (int r = 0; r < DIM1; r++) begin
          for (int c = 0; c < DIM0; c++) begin
            if (r_row_cnt == CW'(r)) begin
              r_bank[r_wr_bank][r][c] <= data_in[c];
            end
          end
        end
        if (w_last_row) begin
          r_row_cnt <= '0;
          r_wr_bank <= (r_wr_bank == BANK_A) ? BANK_B : BANK_A;
        end else begin
          r_row_cnt <= r_row_cnt + 1'b1;
        end
      end
      if (w_out_fire) begin
        r_rd_bank <= (r_rd_bank == BANK_A) ? BANK_B : BANK_A;
      end
      r_full <= w_full_next;
    end
  end

  always_comb begin
    for (int r = 0; r < DIM1; r++) begin
      for (int c = 0; c < DIM0; c++) begin
        w_rd_matrix[r][c] = r_bank[r_rd_bank][r][c];
      end
    end
  end

  matrix_flatten #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM0       (DIM0),
    .DIM1       (DIM1)
  ) u_flatten (
    .i_matrix (w_rd_matrix),
    .o_flat   (data_out)
  );

endmodule : matrix_row_gather

`default_nettype wire
